// File: rtl/button_irq_servicer_if.sv
// Avalon-MM master bus to the button PIO plus the valid/ready event port
// toward the time-keeping logic.
//   master : servicer side (drives bus, sources events)
//   slave  : PIO + event consumer side
interface button_irq_servicer_if #(parameter int WIDTH = 5);
  logic [1:0]       avm_address;
  logic             avm_chipselect;
  logic             avm_write_n;
  logic [31:0]      avm_writedata;
  logic [31:0]      avm_readdata;
  logic             evt_valid;
  logic [WIDTH-1:0] evt_bits;
  logic             evt_ready;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata,
    output evt_valid, evt_bits,
    input  evt_ready
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata,
    input  evt_valid, evt_bits,
    output evt_ready
  );
endinterface

// File: rtl/button_irq_servicer.sv
// Hardware service routine for the edge-capture button PIO.
// After reset it writes irq_mask; on each PIO irq it reads edge_capture,
// clears it, and hands the non-zero capture vector out as an event.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   irq                 PIO interrupt (synchronous to clk)
//   cfg_mask/_update    request to rewrite irq_mask with a new value
//   busy                high whenever the FSM is not in IDLE
//   bus                 Avalon-MM master + event valid/ready port
module button_irq_servicer #(
  parameter int               WIDTH     = 5,
  parameter logic [WIDTH-1:0] MASK_INIT = 5'h1F,
  parameter int               RD_LAT    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             irq,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             cfg_mask_update,
  output logic             busy,
  button_irq_servicer_if.master bus
);
  localparam logic [1:0] A_MASK = 2'd2;
  localparam logic [1:0] A_EDGE = 2'd3;
  localparam int         CW     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    S_INIT_MASK, S_IDLE, S_READ_REQ, S_RD_WAIT, S_CLEAR, S_EMIT
  } state_t;

  state_t           r_state, w_nxt;
  logic [WIDTH-1:0] r_mask;
  logic             r_pend;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_evt_bits;
  logic             w_last;
  logic             w_unused_rd;

  assign w_last      = (r_cnt == CW'(RD_LAT - 1));
  assign w_unused_rd = ^bus.avm_readdata[31:WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_INIT_MASK;
      r_mask     <= MASK_INIT;
      r_pend     <= 1'b0;
      r_cnt      <= '0;
      r_evt_bits <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= (r_state == S_RD_WAIT) ? r_cnt + CW'(1) : '0;
      if (r_state == S_RD_WAIT && w_last)
        r_evt_bits <= bus.avm_readdata[WIDTH-1:0];
      // Last update wins; an update landing during INIT_MASK leaves the
      // in-flight write on the old value and forces a rewrite via r_pend.
      if (cfg_mask_update)
        r_mask <= cfg_mask;
      // IDLE always leaves for INIT_MASK when a rewrite is owed, so the
      // flag is consumed there.
      r_pend <= (r_state == S_IDLE) ? 1'b0 : (r_pend | cfg_mask_update);
    end
  end

  always_comb begin
    w_nxt              = r_state;
    bus.avm_chipselect = 1'b0;
    bus.avm_write_n    = 1'b1;
    bus.avm_address    = 2'd0;
    bus.avm_writedata  = 32'd0;
    bus.evt_valid      = 1'b0;
    case (r_state)
      S_INIT_MASK: begin
        bus.avm_chipselect = 1'b1;
        bus.avm_write_n    = 1'b0;
        bus.avm_address    = A_MASK;
        bus.avm_writedata  = {{(32-WIDTH){1'b0}}, r_mask};
        w_nxt              = S_IDLE;
      end
      S_IDLE: begin
        if (r_pend || cfg_mask_update) w_nxt = S_INIT_MASK;
        else if (irq)                  w_nxt = S_READ_REQ;
      end
      S_READ_REQ: begin
        bus.avm_chipselect = 1'b1;
        bus.avm_address    = A_EDGE;
        w_nxt              = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        bus.avm_address = A_EDGE;
        if (w_last) w_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        bus.avm_chipselect = 1'b1;
        bus.avm_write_n    = 1'b0;
        bus.avm_address    = A_EDGE;
        // Zero capture means a spurious irq: nothing to hand out.
        w_nxt = (r_evt_bits != '0) ? S_EMIT : S_IDLE;
      end
      S_EMIT: begin
        bus.evt_valid = 1'b1;
        if (bus.evt_ready) w_nxt = S_IDLE;
      end
      default: w_nxt = S_INIT_MASK;
    endcase
  end

  assign bus.evt_bits = r_evt_bits;
  assign busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_button_irq_servicer.sv
module tb_button_irq_servicer;
  localparam int ST_IM = 0, ST_ID = 1, ST_RR = 2, ST_RW = 3, ST_CL = 4, ST_EM = 5;

  typedef struct {
    logic [4:0]  inj;
    logic        rdy;
    logic        upd;
    logic [4:0]  cfg;
    logic        cs;
    logic        wn;
    logic [1:0]  a;
    logic [31:0] wd;
    logic        ev;
    logic [4:0]  bits;
    logic        bsy;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       irq;
  logic [4:0] cfg_mask;
  logic       cfg_mask_update;
  logic       busy;

  logic [4:0]  inj;
  logic        zero_rd;
  logic [4:0]  cap   = '0;
  logic [4:0]  pmask = '0;
  logic [31:0] rd_q  = '0;

  int checks = 0;
  int errors = 0;

  button_irq_servicer_if #(.WIDTH(5)) bus ();

  button_irq_servicer #(.WIDTH(5), .MASK_INIT(5'h1F), .RD_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n), .irq(irq), .cfg_mask(cfg_mask),
    .cfg_mask_update(cfg_mask_update), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  // Edge-capture PIO model: registered readdata one cycle after the read
  // request, write-3 clears all capture bits; not reset by reset_n.
  always @(posedge clk) begin
    if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd2)
      pmask <= bus.avm_writedata[4:0];
    if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd3)
      cap <= '0;
    else
      cap <= cap | inj;
    if (bus.avm_chipselect && bus.avm_write_n && bus.avm_address == 2'd3)
      rd_q <= zero_rd ? 32'd0 : {27'd0, cap};
  end
  assign irq              = |(cap & pmask);
  assign bus.avm_readdata = rd_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t V(input int st, input logic [4:0] bits,
                             input logic [4:0] vinj, input logic rdy, input logic [31:0] wd);
    vec_t v;
    v.inj = vinj; v.rdy = rdy; v.upd = 1'b0; v.cfg = 5'd0; v.bits = bits;
    v.cs = 1'b0; v.wn = 1'b1; v.a = 2'd0; v.wd = 32'd0; v.ev = 1'b0; v.bsy = 1'b1;
    case (st)
      ST_IM: begin v.cs = 1'b1; v.wn = 1'b0; v.a = 2'd2; v.wd = wd; end
      ST_ID: v.bsy = 1'b0;
      ST_RR: begin v.cs = 1'b1; v.a = 2'd3; end
      ST_RW: v.a = 2'd3;
      ST_CL: begin v.cs = 1'b1; v.wn = 1'b0; v.a = 2'd3; end
      ST_EM: v.ev = 1'b1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic cmp(input vec_t v, input string nm);
    chk({nm, ".cs"},   {31'd0, bus.avm_chipselect}, {31'd0, v.cs});
    chk({nm, ".wn"},   {31'd0, bus.avm_write_n},    {31'd0, v.wn});
    chk({nm, ".addr"}, {30'd0, bus.avm_address},    {30'd0, v.a});
    chk({nm, ".wd"},   bus.avm_writedata,           v.wd);
    chk({nm, ".ev"},   {31'd0, bus.evt_valid},      {31'd0, v.ev});
    chk({nm, ".bits"}, {27'd0, bus.evt_bits},       {27'd0, v.bits});
    chk({nm, ".busy"}, {31'd0, busy},               {31'd0, v.bsy});
  endtask

  // One clock cycle: drive inputs on the falling edge, then sample outputs.
  task automatic step(input vec_t v, input string nm);
    @(negedge clk);
    inj = v.inj; bus.evt_ready = v.rdy; cfg_mask_update = v.upd; cfg_mask = v.cfg;
    #1 cmp(v, nm);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    reset_n = 1'b0; inj = '0; zero_rd = 1'b0; bus.evt_ready = 1'b0;
    cfg_mask = '0; cfg_mask_update = 1'b0;

    // Reset state: INIT_MASK write presented, no event.
    repeat (3) @(posedge clk);
    @(negedge clk); #1 cmp(V(ST_IM, 5'd0, 5'd0, 1'b0, 32'h1F), "rst");
    @(posedge clk); #2 reset_n = 1'b1;

    // Mask write, bit-2 service, then bit-0 coalesced behind a stalled EMIT.
    tbl.push_back(V(ST_IM, 5'd0, 5'd0,     1'b0, 32'h1F));
    tbl.push_back(V(ST_ID, 5'd0, 5'b00100, 1'b0, 0));
    tbl.push_back(V(ST_ID, 5'd0, 5'd0,     1'b0, 0));
    tbl.push_back(V(ST_RR, 5'd0, 5'd0,     1'b0, 0));
    tbl.push_back(V(ST_RW, 5'd0, 5'd0,     1'b0, 0));
    tbl.push_back(V(ST_CL, 5'b00100, 5'd0, 1'b0, 0));
    tbl.push_back(V(ST_EM, 5'b00100, 5'b00001, 1'b0, 0));
    for (int i = 0; i < 9; i++) tbl.push_back(V(ST_EM, 5'b00100, 5'd0, 1'b0, 0));
    tbl.push_back(V(ST_EM, 5'b00100, 5'd0, 1'b1, 0));
    tbl.push_back(V(ST_ID, 5'b00100, 5'd0, 1'b0, 0));
    tbl.push_back(V(ST_RR, 5'b00100, 5'd0, 1'b0, 0));
    tbl.push_back(V(ST_RW, 5'b00100, 5'd0, 1'b0, 0));
    tbl.push_back(V(ST_CL, 5'b00001, 5'd0, 1'b0, 0));
    tbl.push_back(V(ST_EM, 5'b00001, 5'd0, 1'b1, 0));
    tbl.push_back(V(ST_ID, 5'b00001, 5'd0, 1'b0, 0));
    foreach (tbl[i]) begin
      step(tbl[i], $sformatf("t%0d", i));
      if (i == 6) chk("irq_after_clear", {31'd0, irq}, 32'd0);
    end

    // Mask update during RD_WAIT: event completes, rewrite precedes next service.
    step(V(ST_ID, 5'b00001, 5'b00010, 1'b0, 0), "a0");
    step(V(ST_ID, 5'b00001, 5'd0, 1'b0, 0), "a1");
    step(V(ST_RR, 5'b00001, 5'd0, 1'b0, 0), "a2");
    v = V(ST_RW, 5'b00001, 5'd0, 1'b0, 0); v.upd = 1'b1; v.cfg = 5'h03;
    step(v, "a3");
    step(V(ST_CL, 5'b00010, 5'd0, 1'b0, 0), "a4");
    step(V(ST_EM, 5'b00010, 5'b00001, 1'b0, 0), "a5");
    step(V(ST_EM, 5'b00010, 5'd0, 1'b1, 0), "a6");
    step(V(ST_ID, 5'b00010, 5'd0, 1'b0, 0), "a7");
    step(V(ST_IM, 5'b00010, 5'd0, 1'b0, 32'h03), "a8");
    step(V(ST_ID, 5'b00010, 5'd0, 1'b0, 0), "a9");
    step(V(ST_RR, 5'b00010, 5'd0, 1'b0, 0), "a10");
    step(V(ST_RW, 5'b00010, 5'd0, 1'b0, 0), "a11");
    step(V(ST_CL, 5'b00001, 5'd0, 1'b0, 0), "a12");
    step(V(ST_EM, 5'b00001, 5'd0, 1'b1, 0), "a13");
    step(V(ST_ID, 5'b00001, 5'd0, 1'b0, 0), "a14");

    // Spurious irq: readdata forced to zero, no event.
    zero_rd = 1'b1;
    step(V(ST_ID, 5'b00001, 5'b00010, 1'b0, 0), "b0");
    step(V(ST_ID, 5'b00001, 5'd0, 1'b0, 0), "b1");
    step(V(ST_RR, 5'b00001, 5'd0, 1'b0, 0), "b2");
    step(V(ST_RW, 5'b00001, 5'd0, 1'b0, 0), "b3");
    step(V(ST_CL, 5'd0, 5'd0, 1'b0, 0), "b4");
    step(V(ST_ID, 5'd0, 5'd0, 1'b0, 0), "b5");
    chk("spur_irq", {31'd0, irq}, 32'd0);
    zero_rd = 1'b0;

    // Reset during EMIT with a further edge pending (masked by 0x03 until
    // the post-reset MASK_INIT rewrite).
    step(V(ST_ID, 5'd0, 5'b00001, 1'b0, 0), "c0");
    step(V(ST_ID, 5'd0, 5'd0, 1'b0, 0), "c1");
    step(V(ST_RR, 5'd0, 5'd0, 1'b0, 0), "c2");
    step(V(ST_RW, 5'd0, 5'd0, 1'b0, 0), "c3");
    step(V(ST_CL, 5'b00001, 5'd0, 1'b0, 0), "c4");
    step(V(ST_EM, 5'b00001, 5'b00100, 1'b0, 0), "c5");
    #1 reset_n = 1'b0;
    #1 cmp(V(ST_IM, 5'd0, 5'd0, 1'b0, 32'h1F), "c_rst");
    @(posedge clk); #1 inj = '0; #1 reset_n = 1'b1;
    step(V(ST_IM, 5'd0, 5'd0, 1'b0, 32'h1F), "c6");
    step(V(ST_ID, 5'd0, 5'd0, 1'b0, 0), "c7");
    step(V(ST_RR, 5'd0, 5'd0, 1'b0, 0), "c8");
    step(V(ST_RW, 5'd0, 5'd0, 1'b0, 0), "c9");
    step(V(ST_CL, 5'b00100, 5'd0, 1'b0, 0), "c10");
    step(V(ST_EM, 5'b00100, 5'd0, 1'b1, 0), "c11");
    step(V(ST_ID, 5'b00100, 5'd0, 1'b0, 0), "c12");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
